basic_top: RTL and testbench

Top-level of the basic board demo (DUT `basic`): a system controller (`syscon`) that emulates clock-manager lock and generates a clean internal reset, plus a switch-to-LED datapath. After reset and lock, `LEDS[7]` lights as a "running" indicator and `LEDS[6:0]` follow `SWITCHES[6:0]`. It sits directly on board pins (100 MHz oscillator, reset button, 8 slide switches, 8 LEDs).

---
 rtl/basic_pkg.sv | 9 +
 rtl/basic_syscon.sv | 28 ++
 rtl/basic_top.sv | 32 +++
 tb/tb_basic_top.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/basic_pkg.sv
// basic_pkg: shared constants for the basic board demo.
package basic_pkg;
  localparam int LOCK_CYCLES_DEF = 100;
  localparam int LED_W = 8;
  localparam int LED_RUN_BIT = 7;
  localparam logic [LED_W-1:0] LED_RST = '0;
  localparam logic [LED_W-1:0] SW_RST = '0;
  localparam logic [LED_W-1:0] RUN_MASK = LED_W'(1) << LED_RUN_BIT;
endpackage

// File: rtl/basic_syscon.sv
// basic_syscon: emulated clock-manager lock and clean internal reset generation.
module basic_syscon
  import basic_pkg::*;
#(
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic CLK_IN,
  input  logic RESET_IN,
  output logic LOCKED,
  output logic rst
);
  localparam int CW = $clog2(LOCK_CYCLES + 1) > 7 ? $clog2(LOCK_CYCLES + 1) : 7;
  logic [CW-1:0] cnt, cnt_nxt;
  logic rst_meta;
  always_comb cnt_nxt = (cnt == CW'(LOCK_CYCLES)) ? cnt : cnt + 1'b1;
  always_ff @(posedge CLK_IN or posedge RESET_IN)
    if (RESET_IN) begin
      cnt <= '0;
      LOCKED <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      LOCKED <= LOCKED | (cnt_nxt == CW'(LOCK_CYCLES));
    end
  // Reset asserts asynchronously but releases two edges after lock.
  always_ff @(posedge CLK_IN or posedge RESET_IN)
    if (RESET_IN) {rst, rst_meta} <= 2'b11;
    else {rst, rst_meta} <= {rst_meta, ~LOCKED};
endmodule

// File: rtl/basic_top.sv
// basic_top: board demo top; synchronized switches mirrored to LEDs with a running indicator.
module basic_top
  import basic_pkg::*;
#(
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic             CLK_IN,
  input  logic             RESET_IN,
  input  logic [LED_W-1:0] SWITCHES,
  output logic [LED_W-1:0] LEDS
);
  logic rst, locked;
  logic [LED_W-1:0] sw_meta, sw_sync, led_nxt;
  basic_syscon #(.LOCK_CYCLES(LOCK_CYCLES)) syscon (
    .CLK_IN(CLK_IN),
    .RESET_IN(RESET_IN),
    .LOCKED(locked),
    .rst(rst)
  );
  // OR-ing the run mask overrides the synchronized switch 7 value.
  always_comb led_nxt = sw_sync | (locked ? RUN_MASK : '0);
  always_ff @(posedge CLK_IN or posedge rst)
    if (rst) begin
      sw_meta <= SW_RST;
      sw_sync <= SW_RST;
      LEDS <= LED_RST;
    end else begin
      sw_meta <= SWITCHES;
      sw_sync <= sw_meta;
      LEDS <= led_nxt;
    end
endmodule

// File: tb/tb_basic_top.sv
// tb_basic_top: randomized self-checking bench for basic_top against an edge-count model.
module tb_basic_top;
  localparam int LOCK = 100;
  localparam int RUN = LOCK + 3;
  logic CLK_IN = 1'b0;
  logic RESET_IN = 1'b1;
  logic [7:0] SWITCHES = 8'h00;
  logic [7:0] LEDS;
  int passed = 0, total = 0, e = 0;
  logic [7:0] hist[0:2047];

  basic_top dut (.CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .SWITCHES(SWITCHES), .LEDS(LEDS));

  always #5 CLK_IN = ~CLK_IN;

  // e = rising edges since RESET_IN released; hist[n] = switches sampled at edge n.
  function automatic logic [7:0] model_leds();
    if (e < RUN) return 8'h00;
    if (e - 2 < RUN) return 8'h80;
    return 8'h80 | {1'b0, hist[e-2][6:0]};
  endfunction

  task automatic tick(input logic [7:0] sw);
    SWITCHES = sw;
    @(posedge CLK_IN);
    if (!RESET_IN) begin
      e++;
      hist[e] = sw;
    end
    @(negedge CLK_IN);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 110; i++) begin
      tick(8'($urandom));
      total++;
      if (LEDS !== 8'h00) $display("FAIL reset_leds got=%h exp=00", LEDS); else passed++;
      total++;
      if (dut.syscon.LOCKED !== 1'b0) $display("FAIL reset_locked got=%b exp=0", dut.syscon.LOCKED); else passed++;
    end
  endtask

  task automatic test_lock();
    int lock_e = -1, run_e = -1;
    RESET_IN = 1'b0;
    e = 0;
    for (int i = 0; i < 210; i++) begin
      tick(8'($urandom));
      if (lock_e < 0 && dut.syscon.LOCKED === 1'b1) lock_e = e;
      if (run_e < 0 && LEDS[7] === 1'b1) run_e = e;
      total++;
      if (LEDS !== model_leds()) $display("FAIL lock_leds edge=%0d got=%h exp=%h", e, LEDS, model_leds()); else passed++;
      total++;
      if (dut.syscon.LOCKED !== (e >= LOCK)) $display("FAIL lock_locked edge=%0d got=%b exp=%b", e, dut.syscon.LOCKED, e >= LOCK); else passed++;
    end
    total++;
    if (lock_e != LOCK) $display("FAIL lock_edge got=%0d exp=%0d", lock_e, LOCK); else passed++;
    total++;
    if (run_e < LOCK || run_e - lock_e > 4) $display("FAIL run_latency got=%0d exp<=%0d", run_e, lock_e + 4); else passed++;
  endtask

  task automatic test_mirror();
    for (int i = 0; i < 3; i++) tick(8'hFF);
    total++;
    if (LEDS !== 8'hFF) $display("FAIL mirror got=%h exp=ff", LEDS); else passed++;
  endtask

  task automatic test_mask();
    logic [7:0] sw[3] = '{8'h00, 8'h55, 8'h80};
    logic [7:0] ex[3] = '{8'h80, 8'hD5, 8'h80};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) tick(sw[k]);
      total++;
      if (LEDS !== ex[k]) $display("FAIL mask sw=%h got=%h exp=%h", sw[k], LEDS, ex[k]); else passed++;
    end
  endtask

  task automatic test_midrun_reset();
    for (int i = 0; i < 3; i++) tick(8'hFF);
    total++;
    if (LEDS !== 8'hFF) $display("FAIL midrun_pre got=%h exp=ff", LEDS); else passed++;
    RESET_IN = 1'b1;
    e = 0;
    #1;
    total++;
    if (LEDS !== 8'h00) $display("FAIL midrun_async_leds got=%h exp=00", LEDS); else passed++;
    total++;
    if (dut.syscon.LOCKED !== 1'b0) $display("FAIL midrun_async_locked got=%b exp=0", dut.syscon.LOCKED); else passed++;
    for (int i = 0; i < 3; i++) tick(8'hFF);
    RESET_IN = 1'b0;
    for (int i = 0; i < 110; i++) begin
      tick(8'hFF);
      total++;
      if (LEDS !== model_leds()) $display("FAIL relock_leds edge=%0d got=%h exp=%h", e, LEDS, model_leds()); else passed++;
      total++;
      if (dut.syscon.LOCKED !== (e >= LOCK)) $display("FAIL relock_locked edge=%0d got=%b exp=%b", e, dut.syscon.LOCKED, e >= LOCK); else passed++;
    end
    total++;
    if (LEDS !== 8'hFF) $display("FAIL relock_final got=%h exp=ff", LEDS); else passed++;
  endtask

  task automatic test_prelock_reset();
    RESET_IN = 1'b1;
    e = 0;
    tick(8'h00);
    tick(8'h00);
    RESET_IN = 1'b0;
    for (int i = 0; i < 50; i++) tick(8'($urandom));
    total++;
    if (dut.syscon.LOCKED !== 1'b0) $display("FAIL prelock_mid got=%b exp=0", dut.syscon.LOCKED); else passed++;
    RESET_IN = 1'b1;
    e = 0;
    tick(8'($urandom));
    tick(8'($urandom));
    RESET_IN = 1'b0;
    for (int i = 0; i < 120; i++) begin
      tick(8'($urandom));
      total++;
      if (LEDS !== model_leds()) $display("FAIL prelock_leds edge=%0d got=%h exp=%h", e, LEDS, model_leds()); else passed++;
      total++;
      if (dut.syscon.LOCKED !== (e >= LOCK)) $display("FAIL prelock_locked edge=%0d got=%b exp=%b", e, dut.syscon.LOCKED, e >= LOCK); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      tick(8'($urandom));
      total++;
      if (LEDS !== model_leds()) $display("FAIL b2b_leds edge=%0d got=%h exp=%h", e, LEDS, model_leds()); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_mirror();
    test_mask();
    test_midrun_reset();
    test_prelock_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
